uart_rx_axis_master: RTL and testbench

- Downstream partner of the AXI-Stream-to-UART transmitter: receives the 8N1 serial line and rebuilds 32-bit words from it.
- Presents each word on an AXI4-Stream master interface.
- Closes the loopback path, so words sent into the TX block come back out as stream beats.
- Reports framing errors and output overruns as single-cycle pulses.

---
 rtl/uart_axis_pkg.sv | 6 +
 rtl/uart_rx_byte.sv | 83 ++++++++
 rtl/uart_rx_axis_master.sv | 67 ++++++
 tb/tb_uart_rx_axis_master.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_axis_pkg.sv
// uart_axis_pkg: shared types and sizes for the UART-to-AXI-Stream receive path
package uart_axis_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    localparam int DATA_BITS      = 8;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 byte receiver with 2-flop synchronizer and mid-bit sampling
module uart_rx_byte
    import uart_axis_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic                 byte_valid,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]           sync;
    logic                 rxs;
    rx_state_t            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 valid_n, ferr_n;

    assign rxs     = sync[1];
    assign rx_byte = shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync       <= 2'b11;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync       <= {sync[0], rxd};
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            byte_valid <= valid_n;
            frame_err  <= ferr_n;
        end
    end

    // Half-bit wait in START centres every later sample in its bit cell
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxs) state_n = START;
            end
            START: if (cnt == HALF) begin
                cnt_n     = '0;
                bit_idx_n = '0;
                state_n   = rxs ? IDLE : DATA;
            end
            DATA: if (cnt == FULL) begin
                cnt_n            = '0;
                shreg_n[bit_idx] = rxs;
                bit_idx_n        = bit_idx + 1'b1;
                if (bit_idx == BW'(DATA_BITS - 1)) state_n = STOP;
            end
            STOP: if (cnt == FULL) begin
                cnt_n   = '0;
                valid_n = rxs;
                ferr_n  = !rxs;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: rtl/uart_rx_axis_master.sv
// uart_rx_axis_master: packs received UART bytes into 32-bit AXI-Stream beats
module uart_rx_axis_master
    import uart_axis_pkg::*;
#(
    parameter int CLKS_PER_BIT     = 434,
    parameter int WORDS_PER_PACKET = 4
) (
    input  logic        M_AXIS_ACLK,
    input  logic        M_AXIS_ARESET,
    input  logic        rxd,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TLAST,
    output logic        frame_err,
    output logic        overrun
);
    localparam int BIW = $clog2(BYTES_PER_WORD);
    localparam int WCW = WORDS_PER_PACKET > 1 ? $clog2(WORDS_PER_PACKET) : 1;

    logic                 byte_valid;
    logic [DATA_BITS-1:0] rx_byte;
    logic [BIW-1:0]       byte_idx;
    logic [WCW-1:0]       word_cnt;
    logic [23:0]          word;
    logic                 last_byte, last_word, slot_free, complete;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (M_AXIS_ACLK),
        .rst       (M_AXIS_ARESET),
        .rxd       (rxd),
        .byte_valid(byte_valid),
        .rx_byte   (rx_byte),
        .frame_err (frame_err)
    );

    assign last_byte = byte_idx == BIW'(BYTES_PER_WORD - 1);
    assign last_word = word_cnt == WCW'(WORDS_PER_PACKET - 1);
    assign slot_free = !M_AXIS_TVALID || M_AXIS_TREADY;
    assign complete  = byte_valid && last_byte;

    // Bytes shift in from the top so the first byte ends up in the low lane
    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TLAST  <= 1'b0;
            overrun       <= 1'b0;
            byte_idx      <= '0;
            word_cnt      <= '0;
            word          <= '0;
        end else begin
            overrun <= complete && !slot_free;
            if (frame_err) byte_idx <= '0;
            else if (byte_valid) begin
                byte_idx <= byte_idx + 1'b1;
                word     <= {rx_byte, word[23:8]};
            end
            if (complete && slot_free) begin
                M_AXIS_TVALID <= 1'b1;
                M_AXIS_TDATA  <= {rx_byte, word};
                M_AXIS_TLAST  <= last_word;
                word_cnt      <= last_word ? '0 : word_cnt + 1'b1;
            end else if (M_AXIS_TREADY) M_AXIS_TVALID <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_axis_master.sv
// tb_uart_rx_axis_master: directed loopback-style checks of the UART-to-AXIS receiver
module tb_uart_rx_axis_master;
    localparam int CPB = 8;
    localparam int WPP = 4;

    logic        clk, rst, rxd, tvalid, tready, tlast, frame_err, overrun;
    logic [31:0] tdata;

    int n_cmp, n_bad, cyc, last_stop, rise_cyc, stab_viol;
    int fe_hi, fe_rise, ov_hi, ov_rise;
    logic [31:0] bq_data[$];
    logic        bq_last[$];
    logic        prev_tv, prev_rdy, prev_last, prev_fe, prev_ov;
    logic [31:0] prev_data;

    uart_rx_axis_master #(.CLKS_PER_BIT(CPB), .WORDS_PER_PACKET(WPP)) dut (
        .M_AXIS_ACLK  (clk),
        .M_AXIS_ARESET(rst),
        .rxd          (rxd),
        .M_AXIS_TVALID(tvalid),
        .M_AXIS_TREADY(tready),
        .M_AXIS_TDATA (tdata),
        .M_AXIS_TLAST (tlast),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the stream and pulses mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            prev_tv = 1'b0;
            prev_fe = 1'b0;
            prev_ov = 1'b0;
        end else begin
            if (tvalid && !prev_tv) rise_cyc = cyc;
            if (prev_tv && !prev_rdy && (!tvalid || tdata !== prev_data || tlast !== prev_last))
                stab_viol++;
            if (tvalid && tready) begin
                bq_data.push_back(tdata);
                bq_last.push_back(tlast);
            end
            if (frame_err) fe_hi++;
            if (frame_err && !prev_fe) fe_rise++;
            if (overrun) ov_hi++;
            if (overrun && !prev_ov) ov_rise++;
            prev_tv   = tvalid;
            prev_rdy  = tready;
            prev_data = tdata;
            prev_last = tlast;
            prev_fe   = frame_err;
            prev_ov   = overrun;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] beat_d(input int i);
        return i < bq_data.size() ? bq_data[i] : 32'hxxxxxxxx;
    endfunction

    function automatic logic beat_l(input int i);
        return i < bq_last.size() ? bq_last[i] : 1'bx;
    endfunction

    task automatic clear_stats();
        bq_data.delete();
        bq_last.delete();
        fe_hi = 0; fe_rise = 0; ov_hi = 0; ov_rise = 0;
        stab_viol = 0;
        rise_cyc = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        clear_stats();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        last_stop = cyc;
        if (!stop) begin
            rxd = 1'b1;
            repeat (2 * CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        rst = 1'b1; rxd = 1'b1; tready = 1'b1;
        clear_stats();
        do_reset();
        chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("rst_tdata", tdata, 32'd0);
        chk("rst_tlast", {31'd0, tlast}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);

        // single word, latency from the 4th stop-bit sample
        send_word(32'hAABBCCDD);
        idle(6);
        chk("t1_beats", bq_data.size(), 32'd1);
        chk("t1_data", beat_d(0), 32'hAABBCCDD);
        chk("t1_last", {31'd0, beat_l(0)}, 32'd0);
        chk("t1_latency", rise_cyc, last_stop);
        chk("t1_frame_err", fe_hi, 32'd0);
        chk("t1_overrun", ov_hi, 32'd0);

        // packet framing and word_cnt wrap
        do_reset();
        for (int w = 1; w <= 5; w++) send_word(32'(w));
        idle(6);
        chk("t2_beats", bq_data.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_data%0d", i), beat_d(i), 32'(i + 1));
            chk($sformatf("t2_last%0d", i), {31'd0, beat_l(i)}, {31'd0, i == 3});
        end

        // glitch shorter than half a bit is ignored
        do_reset();
        rxd = 1'b0;
        idle(2);
        rxd = 1'b1;
        idle(40);
        chk("t3_beats", bq_data.size(), 32'd0);
        chk("t3_frame_err", fe_hi, 32'd0);
        send_word(32'h12345678);
        idle(6);
        chk("t3_after_beats", bq_data.size(), 32'd1);
        chk("t3_after_data", beat_d(0), 32'h12345678);

        // framing error discards the partial word
        do_reset();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        send_word(32'h66554433);
        idle(6);
        chk("t4_fe_pulses", fe_rise, 32'd1);
        chk("t4_fe_width", fe_hi, 32'd1);
        chk("t4_beats", bq_data.size(), 32'd1);
        chk("t4_data", beat_d(0), 32'h66554433);
        chk("t4_overrun", ov_hi, 32'd0);

        // backpressure and overrun
        do_reset();
        tready = 1'b0;
        send_word(32'hAABBCCDD);
        send_word(32'h01020304);
        idle(4);
        chk("t5_ov_pulses", ov_rise, 32'd1);
        chk("t5_ov_width", ov_hi, 32'd1);
        chk("t5_no_xfer", bq_data.size(), 32'd0);
        chk("t5_held_valid", {31'd0, tvalid}, 32'd1);
        chk("t5_held_data", tdata, 32'hAABBCCDD);
        tready = 1'b1;
        idle(4);
        chk("t5_beats", bq_data.size(), 32'd1);
        chk("t5_data", beat_d(0), 32'hAABBCCDD);
        chk("t5_valid_low", {31'd0, tvalid}, 32'd0);
        chk("t5_stable", stab_viol, 32'd0);

        // reset mid-byte with word_cnt at the packet's last slot
        send_word(32'h0000AA01);
        send_word(32'h0000AA02);
        idle(4);
        clear_stats();
        send_byte(8'hDD, 1'b1);
        send_byte(8'hCC, 1'b1);
        rxd = 1'b0;
        idle(CPB);
        rxd = 1'b1;
        idle(CPB);
        rxd = 1'b0;
        idle(CPB);
        rst = 1'b1;
        rxd = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("t6_rst_tvalid", {31'd0, tvalid}, 32'd0);
        chk("t6_rst_tdata", tdata, 32'd0);
        chk("t6_rst_tlast", {31'd0, tlast}, 32'd0);
        chk("t6_rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("t6_rst_overrun", {31'd0, overrun}, 32'd0);
        idle(2 * CPB);
        clear_stats();
        send_word(32'hAABBCCDD);
        idle(6);
        chk("t6_beats", bq_data.size(), 32'd1);
        chk("t6_data", beat_d(0), 32'hAABBCCDD);
        chk("t6_last", {31'd0, beat_l(0)}, 32'd0);
        chk("t6_frame_err", fe_hi, 32'd0);
        chk("t6_stable", stab_viol, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
